// File: rtl/adder_pkg.sv
// Shared types and constants for the serial and parallel adder family.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } adder_state_t;

  localparam int ADDER_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/bit_serial_adder_if.sv
// Operand/result bundle for bit_serial_adder; master drives the request, slave returns status and result.
interface bit_serial_adder_if
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/FA.sv
// Single-bit full-adder cell, purely combinational.
module FA (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/bit_serial_adder.sv
// Serial WIDTH-bit adder: one FA cell fed LSB first, carry held in c_q between bits.
// Result appears WIDTH+1 cycles after an accepted start; start outside IDLE is dropped.
module bit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  bit_serial_adder_if.slave    io
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  adder_state_t     state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_nxt;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt;
  logic             c_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;
  logic             s;
  logic             co;

  FA u_fa (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (c_q),
    .s   (s),
    .co  (co)
  );

  // New sum bit enters at the MSB; written this way so WIDTH=1 needs no special case.
  always_comb begin
    sum_nxt            = sum_sr >> 1;
    sum_nxt[WIDTH-1]   = s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      sum_q  <= '0;
      cnt    <= '0;
      c_q    <= 1'b0;
      cout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io.start) begin
            a_sr   <= io.a;
            b_sr   <= io.b;
            c_q    <= io.cin;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_nxt;
          c_q    <= co;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum_q  <= sum_nxt;
            cout_q <= co;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.busy = busy_q;
  assign io.done = done_q;
  assign io.sum  = sum_q;
  assign io.cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder at WIDTH 1, 4 and 8 against an arithmetic reference.
module tb_bit_serial_adder;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bit_serial_adder_if #(.WIDTH(1)) if1 ();
  bit_serial_adder_if #(.WIDTH(4)) if4 ();
  bit_serial_adder_if #(.WIDTH(8)) if8 ();

  bit_serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .io(if1));
  bit_serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .io(if4));
  bit_serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .io(if8));

  task automatic drive(input int w, input logic st, input logic [7:0] a,
                       input logic [7:0] b, input logic c);
    case (w)
      1: begin if1.start = st; if1.a = a[0];   if1.b = b[0];   if1.cin = c; end
      4: begin if4.start = st; if4.a = a[3:0]; if4.b = b[3:0]; if4.cin = c; end
      default: begin if8.start = st; if8.a = a; if8.b = b; if8.cin = c; end
    endcase
  endtask

  function automatic logic [7:0] get_sum(input int w);
    case (w)
      1:       return {7'b0, if1.sum};
      4:       return {4'b0, if4.sum};
      default: return if8.sum;
    endcase
  endfunction

  function automatic logic get_cout(input int w);
    case (w)
      1:       return if1.cout;
      4:       return if4.cout;
      default: return if8.cout;
    endcase
  endfunction

  function automatic logic get_done(input int w);
    case (w)
      1:       return if1.done;
      4:       return if4.done;
      default: return if8.done;
    endcase
  endfunction

  // One full operation; lat counts edges from the accepting edge (1) to the edge raising done.
  task automatic do_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic c,
                       output logic [7:0] s, output logic co, output int lat, output logic stable);
    logic [7:0] s0;
    logic       c0;
    @(negedge clk);
    s0 = get_sum(w);
    c0 = get_cout(w);
    drive(w, 1'b1, a, b, c);
    lat    = 0;
    stable = 1'b1;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) drive(w, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
      if (!get_done(w) && (get_sum(w) !== s0 || get_cout(w) !== c0)) stable = 1'b0;
    end while (!get_done(w) && lat < w + 10);
    s  = get_sum(w);
    co = get_cout(w);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 1'b0, 8'h0, 8'h0, 1'b0);
    drive(4, 1'b0, 8'h0, 8'h0, 1'b0);
    drive(8, 1'b0, 8'h0, 8'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    total++; if (if4.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", if4.busy); end
    total++; if (if4.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", if4.done); end
    total++; if (if4.sum !== 4'h0)  begin bad++; $display("FAIL reset_sum: got %h want 0", if4.sum); end
    total++; if (if4.cout !== 1'b0) begin bad++; $display("FAIL reset_cout: got %b want 0", if4.cout); end
    total++; if (if8.sum !== 8'h0 || if1.sum !== 1'b0)
      begin bad++; $display("FAIL reset_sum_w1w8: got %h/%b want 0/0", if8.sum, if1.sum); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [3:0] va [3] = '{4'b0111, 4'b1111, 4'b1111};
    logic [3:0] vb [3] = '{4'b0101, 4'b0001, 4'b1111};
    logic       vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [3:0] es [3] = '{4'b1100, 4'b0000, 4'b1111};
    logic       ec [3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] s;
    logic       co;
    int         lat;
    logic       st;
    for (int i = 0; i < 3; i++) begin
      do_op(4, {4'b0, va[i]}, {4'b0, vb[i]}, vc[i], s, co, lat, st);
      total++; if (lat !== 5) begin bad++; $display("FAIL dir_latency[%0d]: got %0d want 5", i, lat); end
      total++; if (s[3:0] !== es[i]) begin bad++; $display("FAIL dir_sum[%0d]: got %b want %b", i, s[3:0], es[i]); end
      total++; if (co !== ec[i]) begin bad++; $display("FAIL dir_cout[%0d]: got %b want %b", i, co, ec[i]); end
    end
  endtask

  task automatic test_ignore_start();
    int lat    = 0;
    int extras = 0;
    @(negedge clk); drive(4, 1'b1, 8'h3, 8'h4, 1'b0);
    @(posedge clk); #1; lat++; drive(4, 1'b0, 8'h0, 8'h0, 1'b0);
    @(posedge clk); #1; lat++;
    @(negedge clk); drive(4, 1'b1, 8'h0, 8'h0, 1'b0);
    @(posedge clk); #1; lat++; drive(4, 1'b0, 8'h0, 8'h0, 1'b0);
    while (!if4.done && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    total++; if (lat !== 5) begin bad++; $display("FAIL ign_latency: got %0d want 5", lat); end
    total++; if (if4.sum !== 4'h7 || if4.cout !== 1'b0)
      begin bad++; $display("FAIL ign_result: got %b/%h want 0/7", if4.cout, if4.sum); end
    repeat (12) begin
      @(posedge clk); #1;
      if (if4.done) extras++;
    end
    total++; if (extras !== 0) begin bad++; $display("FAIL ign_not_queued: got %0d extra done want 0", extras); end
    total++; if (if4.busy !== 1'b0) begin bad++; $display("FAIL ign_busy_idle: got %b want 0", if4.busy); end
  endtask

  task automatic test_back_to_back();
    int times[$];
    int cyc = 0;
    @(negedge clk); drive(4, 1'b1, 8'h1, 8'h2, 1'b0);
    repeat (40) begin
      @(posedge clk); #1; cyc++;
      if (if4.done) begin
        times.push_back(cyc);
        total++; if (if4.sum !== 4'h3) begin bad++; $display("FAIL b2b_sum@%0d: got %h want 3", cyc, if4.sum); end
      end
    end
    @(negedge clk); drive(4, 1'b0, 8'h0, 8'h0, 1'b0);
    repeat (8) @(posedge clk);
    total++; if (times.size() !== 6) begin bad++; $display("FAIL b2b_count: got %0d want 6", times.size()); end
    for (int i = 1; i < times.size(); i++) begin
      total++;
      if (times[i] - times[i-1] !== 6)
        begin bad++; $display("FAIL b2b_spacing[%0d]: got %0d want 6", i, times[i] - times[i-1]); end
    end
  endtask

  task automatic test_rst_mid();
    logic [7:0] s;
    logic       co;
    int         lat;
    logic       st;
    int         dones = 0;
    do_op(4, 8'h5, 8'h6, 1'b0, s, co, lat, st);
    @(negedge clk); drive(4, 1'b1, 8'h2, 8'h3, 1'b0);
    @(posedge clk); #1; drive(4, 1'b0, 8'h0, 8'h0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (if4.sum !== 4'hb) begin bad++; $display("FAIL rst_mid_hold: got %h want b", if4.sum); end
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (if4.busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", if4.busy); end
    total++; if (if4.sum !== 4'h0 || if4.cout !== 1'b0)
      begin bad++; $display("FAIL rst_mid_result: got %b/%h want 0/0", if4.cout, if4.sum); end
    @(negedge clk); rst = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (if4.done) dones++;
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL rst_mid_no_done: got %0d want 0", dones); end
  endtask

  task automatic test_rst_start();
    @(negedge clk); rst = 1'b1; drive(4, 1'b1, 8'h7, 8'h7, 1'b1);
    @(posedge clk); #1;
    total++; if (if4.busy !== 1'b0) begin bad++; $display("FAIL rst_start_busy: got %b want 0", if4.busy); end
    @(negedge clk); rst = 1'b0; drive(4, 1'b0, 8'h0, 8'h0, 1'b0);
    @(posedge clk); #1;
    total++; if (if4.busy !== 1'b0 || if4.done !== 1'b0)
      begin bad++; $display("FAIL rst_start_idle: got busy=%b done=%b want 0/0", if4.busy, if4.done); end
  endtask

  task automatic test_random();
    int         widths [3] = '{1, 4, 8};
    logic [7:0] s;
    logic       co;
    int         lat;
    logic       st;
    for (int k = 0; k < 3; k++) begin
      int         w = widths[k];
      logic [7:0] m = 8'((1 << w) - 1);
      for (int n = 0; n < 1000; n++) begin
        logic [7:0] a = 8'($urandom) & m;
        logic [7:0] b = 8'($urandom) & m;
        logic       c = 1'($urandom);
        int         exp_v = (int'(a) + int'(b) + int'(c)) % (1 << (w + 1));
        int         got_v;
        do_op(w, a, b, c, s, co, lat, st);
        got_v = (int'(co) << w) | int'(s);
        total++; if (got_v !== exp_v)
          begin bad++; $display("FAIL rnd_w%0d_result: a=%h b=%h cin=%b got %h want %h", w, a, b, c, got_v, exp_v); end
        total++; if (lat !== w + 1)
          begin bad++; $display("FAIL rnd_w%0d_latency: got %0d want %0d", w, lat, w + 1); end
        total++; if (st !== 1'b1)
          begin bad++; $display("FAIL rnd_w%0d_stable: result moved before done (got %b want 1)", w, st); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_rst_mid();
    test_rst_start();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
